// File: rtl/pcie_dma_pkg.sv
// rtl/pcie_dma_pkg.sv - shared FSM state, data/address types and word size for the host responder
package pcie_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    WR_RESP,
    GAP
  } hostState_t;

  typedef logic [127:0] dmaData_t;
  typedef logic [63:0]  dmaAddr_t;

  localparam int WORD_BYTES = 16;

endpackage

// File: rtl/pcie_host_mem.sv
// rtl/pcie_host_mem.sv - single-port synchronous host memory, 128-bit words, contents not reset
module pcie_host_mem
  import pcie_dma_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  dmaData_t              wData,
  output dmaData_t              rData
);

  dmaData_t mem [2**DEPTH_LOG2];

  // Read-before-write: rData shows the old word on a write cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wData;
    end
    rData <= mem[addr];
  end

endmodule

// File: rtl/pcie_host_rsp.sv
// rtl/pcie_host_rsp.sv - host memory responder serving read/write requests over one memory port
// Optional periodic error injection is enabled by defining PCIE_HOST_RSP_ERR_INJ_EN.
module pcie_host_rsp
  import pcie_dma_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 6,
  parameter int          RD_LAT     = 2,
  parameter logic [63:0] BASE_ADDR  = 64'h0
`ifdef PCIE_HOST_RSP_ERR_INJ_EN
  ,
  parameter int          ERR_INJ_PERIOD = 8
`endif
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     RdRqValid,
  input  dmaAddr_t RdRqAddr,
  output dmaData_t RdRqData,
  output logic     RdRqReady,
  output logic     RdRqErr,
  input  logic     WrRqValid,
  input  dmaAddr_t WrRqAddr,
  input  dmaData_t WrRqData,
  output logic     WrRqReady,
  output logic     WrRqErr
);

  localparam int         WORD_SHIFT = $clog2(WORD_BYTES);
  localparam logic [3:0] WAIT_LAST  = 4'(RD_LAT > 1 ? RD_LAT - 2 : 0);

  hostState_t            state, nextState;
  logic                  lastWr, anyServed, errReg, injNow;
  logic [3:0]            waitCnt;
  logic [DEPTH_LOG2-1:0] rdIdx, memAddr;
  logic                  memWe;
  dmaData_t              memRData;
  logic                  rdBad, wrBad, pickWr, acceptRd, acceptWr;

  function automatic logic addrBad(input dmaAddr_t a);
    return (a[WORD_SHIFT-1:0] != '0) || (a < BASE_ADDR) ||
           (((a - BASE_ADDR) >> (WORD_SHIFT + DEPTH_LOG2)) != 64'd0);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] wordIdx(input dmaAddr_t a);
    return DEPTH_LOG2'((a - BASE_ADDR) >> WORD_SHIFT);
  endfunction

  assign rdBad = addrBad(RdRqAddr);
  assign wrBad = addrBad(WrRqAddr);

  // On contention the direction not served last wins; before any grant, read wins.
  assign pickWr   = WrRqValid && (!RdRqValid || (anyServed && !lastWr));
  assign acceptWr = (state == IDLE) && pickWr;
  assign acceptRd = (state == IDLE) && RdRqValid && !pickWr;

  assign memAddr = (state == IDLE) ? (pickWr ? wordIdx(WrRqAddr) : wordIdx(RdRqAddr)) : rdIdx;
  assign memWe   = acceptWr && !wrBad && !injNow;

`ifdef PCIE_HOST_RSP_ERR_INJ_EN
  logic [15:0] reqCnt;

  assign injNow = (reqCnt == 16'(ERR_INJ_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reqCnt <= '0;
    end else if (acceptRd || acceptWr) begin
      reqCnt <= injNow ? '0 : reqCnt + 16'd1;
    end
  end
`else
  assign injNow = 1'b0;
`endif

  pcie_host_mem #(.DEPTH_LOG2(DEPTH_LOG2)) uMem (
    .clk   (clk),
    .we    (memWe),
    .addr  (memAddr),
    .wData (WrRqData),
    .rData (memRData)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (acceptWr) begin
          nextState = WR_RESP;
        end else if (acceptRd) begin
          nextState = (RD_LAT > 1) ? RD_WAIT : RD_RESP;
        end
      end
      RD_WAIT: if (waitCnt == WAIT_LAST) nextState = RD_RESP;
      RD_RESP: nextState = GAP;
      WR_RESP: nextState = GAP;
      GAP:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    RdRqReady = (state == RD_RESP);
    WrRqReady = (state == WR_RESP);
    RdRqErr   = RdRqReady && errReg;
    WrRqErr   = WrRqReady && errReg;
    RdRqData  = (RdRqReady && !errReg) ? memRData : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastWr    <= 1'b0;
      anyServed <= 1'b0;
      errReg    <= 1'b0;
      waitCnt   <= '0;
      rdIdx     <= '0;
    end else begin
      if (acceptRd) begin
        rdIdx     <= wordIdx(RdRqAddr);
        errReg    <= rdBad || injNow;
        lastWr    <= 1'b0;
        anyServed <= 1'b1;
      end else if (acceptWr) begin
        errReg    <= wrBad || injNow;
        lastWr    <= 1'b1;
        anyServed <= 1'b1;
      end
      waitCnt <= (state == RD_WAIT) ? waitCnt + 4'd1 : '0;
    end
  end

endmodule
